// File: rtl/ceu_local_query_engine_if.sv
// DMA write-request stream between the local query engine and the DMA write arbiter.
// A beat transfers on a clock edge where valid & ready are both high; once valid rises,
// valid, data, last and head hold steady until that edge, and ready may toggle freely.
interface ceu_local_query_engine_if #(
  parameter int DATA_WIDTH = 256,
  parameter int HEAD_WIDTH = 128
);
  logic                  dma_wr_req_valid;
  logic                  dma_wr_req_last;
  logic [DATA_WIDTH-1:0] dma_wr_req_data;
  logic [HEAD_WIDTH-1:0] dma_wr_req_head;
  logic                  dma_wr_req_ready;

  modport master (
    output dma_wr_req_valid, dma_wr_req_last, dma_wr_req_data, dma_wr_req_head,
    input  dma_wr_req_ready
  );

  modport slave (
    input  dma_wr_req_valid, dma_wr_req_last, dma_wr_req_data, dma_wr_req_head,
    output dma_wr_req_ready
  );
endinterface

// File: rtl/ceu_local_query_engine.sv
// Programmable CEU local-query responder: matches an opcode against config slots and
// DMA-writes a run of info-table entries to the command outbox.
module ceu_local_query_engine #(
  parameter int DATA_WIDTH = 256,
  parameter int HEAD_WIDTH = 128,
  parameter int NUM_CMDS   = 4,
  parameter int MAX_BEATS  = 4,
  parameter int TBL_DEPTH  = 16,
  localparam int AW = $clog2(TBL_DEPTH),
  localparam int BW = $clog2(MAX_BEATS + 1),
  localparam int SW = $clog2(NUM_CMDS),
  localparam int CW = 12 + 1 + AW + BW + 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [11:0]           op,
  input  logic [63:0]           outbox_addr,
  output logic                  busy,
  output logic                  finish,
  output logic                  bad_op,
  input  logic                  cfg_wr_en,
  input  logic [SW-1:0]         cfg_wr_sel,
  input  logic [CW-1:0]         cfg_wr_data,
  input  logic                  tbl_wr_en,
  input  logic [AW-1:0]         tbl_wr_addr,
  input  logic [DATA_WIDTH-1:0] tbl_wr_data,
  output logic                  cfg_wr_err,
  output logic [3:0]            dbg_state,
  ceu_local_query_engine_if.master dma
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    LOOKUP = 4'b0010,
    SEND   = 4'b0100,
    RESP   = 4'b1000
  } state_t;

  state_t state;

  logic [11:0]           slot_op    [NUM_CMDS];
  logic                  slot_valid [NUM_CMDS];
  logic [AW-1:0]         slot_base  [NUM_CMDS];
  logic [BW-1:0]         slot_beats [NUM_CMDS];
  logic [11:0]           slot_len   [NUM_CMDS];
  logic [DATA_WIDTH-1:0] tbl        [TBL_DEPTH];

  logic [11:0]   op_q;
  logic [63:0]   addr_q;
  logic [AW-1:0] base_q;
  logic [BW-1:0] beats_q;
  logic [BW-1:0] cnt_q;

  logic [11:0]   wr_op;
  logic          wr_valid;
  logic [AW-1:0] wr_base;
  logic [BW-1:0] wr_beats;
  logic [11:0]   wr_len;
  logic [BW-1:0] wr_beats_c;

  assign wr_op      = cfg_wr_data[CW-1 -: 12];
  assign wr_valid   = cfg_wr_data[CW-13];
  assign wr_base    = cfg_wr_data[BW+12 +: AW];
  assign wr_beats   = cfg_wr_data[12 +: BW];
  assign wr_len     = cfg_wr_data[11:0];
  assign wr_beats_c = (wr_beats > BW'(MAX_BEATS)) ? BW'(MAX_BEATS) : wr_beats;

  assign busy      = (state != IDLE);
  assign bad_op    = (state == RESP);
  assign finish    = (state == RESP) ||
                     ((state == SEND) && dma.dma_wr_req_ready && dma.dma_wr_req_last);
  assign dbg_state = state;

  // Writes land only while idle, so the tables never change under a response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CMDS; i++) begin
        slot_op[i]    <= '0;
        slot_valid[i] <= 1'b0;
        slot_base[i]  <= '0;
        slot_beats[i] <= '0;
        slot_len[i]   <= '0;
      end
      for (int j = 0; j < TBL_DEPTH; j++) tbl[j] <= '0;
      cfg_wr_err <= 1'b0;
    end else begin
      cfg_wr_err <= busy && (cfg_wr_en || tbl_wr_en);
      if (!busy && cfg_wr_en) begin
        slot_op[cfg_wr_sel]    <= wr_op;
        slot_valid[cfg_wr_sel] <= wr_valid;
        slot_base[cfg_wr_sel]  <= wr_base;
        slot_beats[cfg_wr_sel] <= wr_beats_c;
        slot_len[cfg_wr_sel]   <= wr_len;
      end
      if (!busy && tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  logic          hit;
  logic [AW-1:0] hit_base;
  logic [BW-1:0] hit_beats;
  logic [11:0]   hit_len;

  // Scan downwards so the lowest matching slot index is the one left standing.
  always_comb begin
    hit       = 1'b0;
    hit_base  = '0;
    hit_beats = '0;
    hit_len   = '0;
    for (int i = NUM_CMDS - 1; i >= 0; i--) begin
      if (slot_valid[i] && (slot_op[i] == op_q)) begin
        hit       = 1'b1;
        hit_base  = slot_base[i];
        hit_beats = slot_beats[i];
        hit_len   = slot_len[i];
      end
    end
  end

  logic [BW-1:0] nxt_cnt;
  logic [AW-1:0] nxt_idx;

  assign nxt_cnt = cnt_q + 1'b1;
  assign nxt_idx = base_q + AW'(nxt_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      op_q                 <= '0;
      addr_q               <= '0;
      base_q               <= '0;
      beats_q              <= '0;
      cnt_q                <= '0;
      dma.dma_wr_req_valid <= 1'b0;
      dma.dma_wr_req_last  <= 1'b0;
      dma.dma_wr_req_data  <= '0;
      dma.dma_wr_req_head  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            addr_q <= outbox_addr;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit && (hit_beats != '0)) begin
            base_q               <= hit_base;
            beats_q              <= hit_beats;
            cnt_q                <= '0;
            dma.dma_wr_req_valid <= 1'b1;
            dma.dma_wr_req_data  <= tbl[hit_base];
            dma.dma_wr_req_last  <= (hit_beats == BW'(1));
            dma.dma_wr_req_head  <= HEAD_WIDTH'({32'd0, addr_q, 20'd0, hit_len});
            state                <= SEND;
          end else begin
            state <= RESP;
          end
        end
        SEND: begin
          // The next beat is prefetched on each handshake so outputs stay registered.
          if (dma.dma_wr_req_ready) begin
            if (dma.dma_wr_req_last) begin
              dma.dma_wr_req_valid <= 1'b0;
              dma.dma_wr_req_last  <= 1'b0;
              dma.dma_wr_req_data  <= '0;
              dma.dma_wr_req_head  <= '0;
              state                <= IDLE;
            end else begin
              cnt_q               <= nxt_cnt;
              dma.dma_wr_req_data <= tbl[nxt_idx];
              dma.dma_wr_req_last <= (nxt_cnt == beats_q - 1'b1);
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ceu_local_query_engine.sv
// Self-checking bench for ceu_local_query_engine: directed corner cases plus randomized
// commands compared against a slot/table reference model.
module tb_ceu_local_query_engine;
  localparam int DW = 256;
  localparam int HW = 128;
  localparam int CW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [11:0]   op = '0;
  logic [63:0]   outbox_addr = '0;
  logic          busy, finish, bad_op, cfg_wr_err;
  logic          cfg_wr_en = 1'b0;
  logic [1:0]    cfg_wr_sel = '0;
  logic [CW-1:0] cfg_wr_data = '0;
  logic          tbl_wr_en = 1'b0;
  logic [3:0]    tbl_wr_addr = '0;
  logic [DW-1:0] tbl_wr_data = '0;
  logic [3:0]    dbg_state;
  logic          ready = 1'b0;

  ceu_local_query_engine_if #(.DATA_WIDTH(DW), .HEAD_WIDTH(HW)) dma ();
  assign dma.dma_wr_req_ready = ready;

  ceu_local_query_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .outbox_addr(outbox_addr),
    .busy(busy), .finish(finish), .bad_op(bad_op),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_sel(cfg_wr_sel), .cfg_wr_data(cfg_wr_data),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .cfg_wr_err(cfg_wr_err), .dbg_state(dbg_state), .dma(dma)
  );

  // reference model
  logic [11:0]   m_op    [4];
  bit            m_v     [4];
  int            m_base  [4];
  int            m_beats [4];
  logic [11:0]   m_len   [4];
  logic [DW-1:0] m_tbl   [16];
  logic [11:0]   pool    [4];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_op[i] = '0; m_v[i] = 1'b0; m_base[i] = 0; m_beats[i] = 0; m_len[i] = '0;
    end
    for (int j = 0; j < 16; j++) m_tbl[j] = '0;
  endtask

  // driver tasks
  task automatic cfg_write(input int sel, input logic [11:0] o, input bit v, input int base,
                           input int beats, input int len);
    logic [3:0]  b4;
    logic [2:0]  bt;
    logic [11:0] l12;
    b4 = base[3:0]; bt = beats[2:0]; l12 = len[11:0];
    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_wr_sel = sel[1:0]; cfg_wr_data = {o, v, b4, bt, l12};
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    m_op[sel] = o; m_v[sel] = v; m_base[sel] = int'(b4);
    m_beats[sel] = (int'(bt) > 4) ? 4 : int'(bt);
    m_len[sel] = l12;
  endtask

  task automatic tbl_write(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    tbl_wr_en = 1'b1; tbl_wr_addr = a[3:0]; tbl_wr_data = d;
    @(posedge clk); #1;
    tbl_wr_en = 1'b0;
    m_tbl[a % 16] = d;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // mode 0: ready held high, 1: random ready, 2: ready low for the first 3 SEND cycles.
  // inject: a dropped table write and an ignored start are issued during the response.
  task automatic run_cmd(input logic [11:0] o, input logic [63:0] a, input int mode,
                         input bit inject);
    logic [DW-1:0] exp_q[$];
    logic [HW-1:0] eh;
    logic [DW-1:0] prev_data;
    logic [HW-1:0] prev_head;
    int  sel, nb, cyc;
    bit  bad, done, prev_stall;
    sel = -1; nb = 0; eh = '0;
    for (int i = 0; i < 4; i++)
      if (sel < 0 && m_v[i] && m_op[i] == o) sel = i;
    if (sel >= 0) nb = m_beats[sel];
    bad = (nb == 0);
    if (!bad) begin
      eh = {32'd0, a, 20'd0, m_len[sel]};
      for (int k = 0; k < nb; k++) exp_q.push_back(m_tbl[(m_base[sel] + k) % 16]);
    end

    @(posedge clk); #1;
    start = 1'b1; op = o; outbox_addr = a; ready = (mode == 0);
    @(posedge clk); #1;
    start = 1'b0; op = '0;
    @(negedge clk);
    chk("lookup_busy", busy, 1);
    chk("lookup_valid", dma.dma_wr_req_valid, 0);
    chk("lookup_finish", finish, 0);

    cyc = 1; done = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_head = '0;
    while (!done && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        default: ready = (cyc >= 5);
      endcase
      if (inject && cyc == 2) begin
        tbl_wr_en = 1'b1; tbl_wr_addr = 4'(m_base[sel]); tbl_wr_data = rnd_data();
        start = 1'b1; op = 12'h0FF;
      end else if (inject && cyc == 3) begin
        tbl_wr_en = 1'b0; start = 1'b0; op = '0;
      end
      @(negedge clk);
      if (inject && cyc == 3) chk("wr_err_pulse", cfg_wr_err, 1);
      if (bad) begin
        chk("bad_no_valid", dma.dma_wr_req_valid, 0);
        chk("bad_finish", finish, (cyc == 2));
        if (cyc == 2) begin
          chk("bad_op_flag", bad_op, 1);
          done = 1'b1;
        end
      end else if (dma.dma_wr_req_valid) begin
        chk("beat_data", dma.dma_wr_req_data, exp_q[0]);
        chk("beat_head", dma.dma_wr_req_head, eh);
        chk("beat_last", dma.dma_wr_req_last, (exp_q.size() == 1));
        if (prev_stall) begin
          chk("stall_data", dma.dma_wr_req_data, prev_data);
          chk("stall_head", dma.dma_wr_req_head, prev_head);
        end
        if (ready) begin
          void'(exp_q.pop_front());
          chk("beat_finish", finish, (exp_q.size() == 0));
          if (exp_q.size() == 0) begin
            chk("good_bad_op", bad_op, 0);
            if (mode == 0) chk("finish_latency", cyc, 1 + nb);
            done = 1'b1;
          end
        end else begin
          chk("stall_finish", finish, 0);
        end
        prev_stall = !ready;
        prev_data  = dma.dma_wr_req_data;
        prev_head  = dma.dma_wr_req_head;
      end else begin
        chk("valid_missing", dma.dma_wr_req_valid, 1);
      end
      if (!bad && cyc == 2) chk("first_beat_latency", dma.dma_wr_req_valid, 1);
    end
    if (!done) chk("cmd_timeout", done, 1);
    tbl_wr_en = 1'b0; start = 1'b0;

    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    chk("post_busy", busy, 0);
    chk("post_valid", dma.dma_wr_req_valid, 0);
    chk("post_finish", finish, 0);
  endtask

  initial begin
    model_reset();
    pool[0] = 12'h003; pool[1] = 12'h00A; pool[2] = 12'h0B0; pool[3] = 12'h0FF;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_bad_op", bad_op, 0);
    chk("rst_wr_err", cfg_wr_err, 0);
    chk("rst_valid", dma.dma_wr_req_valid, 0);
    chk("rst_head", dma.dma_wr_req_head, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // two-beat response, ready high
    cfg_write(0, 12'h003, 1, 0, 2, 12'h100);
    tbl_write(0, {8{32'hAAAA_0000}});
    tbl_write(1, {8{32'hBBBB_1111}});
    run_cmd(12'h003, 64'h1_0000_0040, 0, 0);
    // back-pressure on beat 0
    run_cmd(12'h003, 64'h1_0000_0040, 2, 0);
    // unsupported opcode
    run_cmd(12'h0FF, 64'h2000, 0, 0);
    // duplicate opcode: lowest slot wins
    cfg_write(1, 12'h00A, 1, 2, 1, 12'h020);
    cfg_write(2, 12'h00A, 1, 5, 3, 12'h060);
    tbl_write(2, rnd_data());
    run_cmd(12'h00A, 64'hDEAD_BEEF_0000_1000, 0, 0);
    // table index wraps
    tbl_write(15, rnd_data());
    cfg_write(3, 12'h0B0, 1, 15, 3, 12'h060);
    run_cmd(12'h0B0, 64'h3000, 0, 0);
    // beats clamp and zero-beat slot
    cfg_write(3, 12'h0C0, 1, 3, 7, 12'h080);
    run_cmd(12'h0C0, 64'h4000, 0, 0);
    cfg_write(3, 12'h0D0, 1, 0, 0, 12'h010);
    run_cmd(12'h0D0, 64'h5000, 0, 0);
    // dropped write and ignored start mid-response, then confirm table unchanged
    run_cmd(12'h003, 64'h6000, 2, 1);
    run_cmd(12'h003, 64'h7000, 0, 0);

    // async reset mid-SEND
    @(posedge clk); #1;
    start = 1'b1; op = 12'h003; outbox_addr = 64'h8000; ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", dma.dma_wr_req_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", dma.dma_wr_req_valid, 0);
    chk("abort_finish", finish, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_cmd(12'h003, 64'h9000, 0, 0);
    cfg_write(0, 12'h003, 1, 0, 2, 12'h100);
    run_cmd(12'h003, 64'h9000, 0, 0);

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: cfg_write(int'($urandom_range(0, 3)),
                     ($urandom_range(0, 4) == 0) ? 12'($urandom) : pool[$urandom_range(0, 3)],
                     bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
        1: tbl_write(int'($urandom_range(0, 15)), rnd_data());
        default: ;
      endcase
      run_cmd(pool[$urandom_range(0, 3)], {32'($urandom), 32'($urandom)},
              int'($urandom_range(0, 2)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "bench timed out");
  end
endmodule
